// File: rtl/clk_div_bank.sv
//==============================================================================
// Module      : clk_div_bank
// Description : Multi-channel clock-enable bank; per-channel tick strobe and
//               50% duty toggle at a runtime-programmable divisor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module clk_div_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIV = {NUM_CH{CNT_W'(10000)}}
) (
  input  logic                                        clk100MHz,
  input  logic                                        rst,
  input  logic [NUM_CH-1:0]                           ch_en,
  input  logic                                        sync_restart,
  input  logic                                        cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                            cfg_div,
  input  logic                                        cfg_now,
  output logic [NUM_CH-1:0]                           tick,
  output logic [NUM_CH-1:0]                           clk_out,
  output logic [NUM_CH*CNT_W-1:0]                     div_active
);

  localparam int               c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_ZERO = '0;

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      // Out-of-range cfg_ch values never match any channel index, so they are ignored.
      localparam logic [c_CH_W-1:0] c_IDX = c_CH_W'(i);

      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_div;
      logic [CNT_W-1:0] r_shadow;
      logic             r_pending;
      logic             r_tick;
      logic             r_clk;
      logic             w_wr;
      logic             w_run;
      logic             w_wrap;

      assign w_wr   = cfg_we && (cfg_ch == c_IDX);
      assign w_run  = ch_en[i] && (r_div != c_ZERO);
      assign w_wrap = w_run && (r_cnt == r_div - c_ONE);

      always_ff @(posedge clk100MHz) begin
        if (rst) begin
          r_cnt     <= c_ZERO;
          r_div     <= DEFAULT_DIV[i*CNT_W +: CNT_W];
          r_shadow  <= DEFAULT_DIV[i*CNT_W +: CNT_W];
          r_pending <= 1'b0;
          r_tick    <= 1'b0;
          r_clk     <= 1'b0;
        end else begin
          r_tick <= 1'b0;
          if (sync_restart) begin
            r_cnt <= c_ZERO;
            r_clk <= 1'b0;
            if (w_wr && cfg_now) begin
              r_div     <= cfg_div;
              r_pending <= 1'b0;
            end else if (w_wr) begin
              r_shadow  <= cfg_div;
              r_pending <= 1'b1;
            end
          end else if (w_wr && cfg_now) begin
            r_div     <= cfg_div;
            r_cnt     <= c_ZERO;
            r_clk     <= 1'b0;
            r_pending <= 1'b0;
          end else begin
            if (w_wrap) begin
              r_tick <= 1'b1;
              r_clk  <= ~r_clk;
              r_cnt  <= c_ZERO;
              if (r_pending) begin
                r_div     <= r_shadow;
                r_pending <= 1'b0;
              end
            end else if (w_run) begin
              r_cnt <= r_cnt + c_ONE;
            end
            // Placed after the wrap so a write on the wrap cycle stays pending.
            if (w_wr) begin
              r_shadow  <= cfg_div;
              r_pending <= 1'b1;
            end
          end
        end
      end

      assign tick[i]                        = r_tick;
      assign clk_out[i]                     = r_clk;
      assign div_active[i*CNT_W +: CNT_W]   = r_div;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clk_div_bank.sv
//==============================================================================
// Module      : tb_clk_div_bank
// Description : Directed self-checking bench for clk_div_bank (3 channels).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_clk_div_bank;

  localparam int c_NCH = 3;
  localparam int c_W   = 32;

  logic                   clk100MHz = 1'b0;
  logic                   rst;
  logic [c_NCH-1:0]       ch_en;
  logic                   sync_restart;
  logic                   cfg_we;
  logic [1:0]             cfg_ch;
  logic [c_W-1:0]         cfg_div;
  logic                   cfg_now;
  logic [c_NCH-1:0]       tick;
  logic [c_NCH-1:0]       clk_out;
  logic [c_NCH*c_W-1:0]   div_active;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk100MHz = ~clk100MHz;

  clk_div_bank #(
    .NUM_CH     (c_NCH),
    .CNT_W      (c_W),
    .DEFAULT_DIV({c_NCH{32'd10000}})
  ) dut (
    .clk100MHz   (clk100MHz),
    .rst         (rst),
    .ch_en       (ch_en),
    .sync_restart(sync_restart),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_now     (cfg_now),
    .tick        (tick),
    .clk_out     (clk_out),
    .div_active  (div_active)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk100MHz);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [31:0] d, input logic now);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = d;
    cfg_now = now;
    step(1);
    cfg_we  = 1'b0;
    cfg_now = 1'b0;
  endtask

  function automatic logic [95:0] dv(input logic [31:0] d0, input logic [31:0] d1,
                                     input logic [31:0] d2);
    return {d2, d1, d0};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ch_en = '0; sync_restart = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_now = 1'b0;
    step(2);
    check("rst_tick", 96'(tick), 96'(3'b000));
    check("rst_clk", 96'(clk_out), 96'(3'b000));
    check("rst_div", div_active, dv(10000, 10000, 10000));

    // Default rate: tick on edge 10000, clk_out period 20000
    rst = 1'b0; ch_en = 3'b111;
    step(9999);
    check("t1_pre", 96'(tick), 96'(3'b000));
    step(1);
    check("t1_tick", 96'(tick), 96'(3'b111));
    check("t1_clk", 96'(clk_out), 96'(3'b111));
    step(1);
    check("t1_post", 96'(tick), 96'(3'b000));
    step(9998);
    check("t1_pre2", 96'(tick), 96'(3'b000));
    step(1);
    check("t1_tick2", 96'(tick), 96'(3'b111));
    check("t1_clk2", 96'(clk_out), 96'(3'b000));

    // Immediate write ch1 div=4
    wr(2'd1, 32'd4, 1'b1);
    check("t2_div", 96'(div_active[63:32]), 96'(4));
    check("t2_clk", 96'(clk_out[1]), 96'(0));
    step(3);
    check("t2_pre", 96'(tick[1]), 96'(0));
    step(1);
    check("t2_tick", 96'(tick[1]), 96'(1));
    check("t2_clkhi", 96'(clk_out[1]), 96'(1));
    step(4);
    check("t2_tick2", 96'(tick[1]), 96'(1));
    check("t2_clklo", 96'(clk_out[1]), 96'(0));
    check("t2_ch0_quiet", 96'(tick[0]), 96'(0));

    // Deferred write ch0 div=3
    wr(2'd0, 32'd3, 1'b0);
    check("t3_div_old", 96'(div_active[31:0]), 96'(10000));
    step(9989);
    check("t3_pre", 96'(tick[0]), 96'(0));
    check("t3_div_still", 96'(div_active[31:0]), 96'(10000));
    step(1);
    check("t3_wrap_tick", 96'(tick[0]), 96'(1));
    check("t3_wrap_div", 96'(div_active[31:0]), 96'(3));
    check("t3_wrap_clk", 96'(clk_out[0]), 96'(1));
    step(2);
    check("t3_gap", 96'(tick[0]), 96'(0));
    step(1);
    check("t3_tick3", 96'(tick[0]), 96'(1));
    check("t3_clk3", 96'(clk_out[0]), 96'(0));

    // div=1 on ch2, then deferred div=0 landing on a wrap cycle
    wr(2'd2, 32'd1, 1'b1);
    check("t4_w_tick", 96'(tick[2]), 96'(0));
    step(1);
    check("t4_tick1", 96'(tick[2]), 96'(1));
    check("t4_clk1", 96'(clk_out[2]), 96'(1));
    step(1);
    check("t4_tick2", 96'(tick[2]), 96'(1));
    check("t4_clk2", 96'(clk_out[2]), 96'(0));
    step(1);
    check("t4_clk3", 96'(clk_out[2]), 96'(1));
    wr(2'd2, 32'd0, 1'b0);
    check("t4_wrapwr_tick", 96'(tick[2]), 96'(1));
    check("t4_wrapwr_div", 96'(div_active[95:64]), 96'(1));
    check("t4_wrapwr_clk", 96'(clk_out[2]), 96'(0));
    step(1);
    check("t4_apply_div", 96'(div_active[95:64]), 96'(0));
    check("t4_apply_clk", 96'(clk_out[2]), 96'(1));
    step(1);
    check("t4_stop_tick", 96'(tick[2]), 96'(0));
    step(4);
    check("t4_stop_tick2", 96'(tick[2]), 96'(0));
    check("t4_frozen_clk", 96'(clk_out[2]), 96'(1));

    // Pause ch0 (div=10) for 7 cycles mid-count
    wr(2'd0, 32'd10, 1'b1);
    step(5);
    ch_en = 3'b110;
    step(7);
    check("t5_paused", 96'(tick[0]), 96'(0));
    ch_en = 3'b111;
    step(4);
    check("t5_pre", 96'(tick[0]), 96'(0));
    step(1);
    check("t5_tick", 96'(tick[0]), 96'(1));
    check("t5_clk", 96'(clk_out[0]), 96'(1));

    // sync_restart together with an immediate write of ch2 div=2
    sync_restart = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 32'd2; cfg_now = 1'b1;
    step(1);
    sync_restart = 1'b0; cfg_we = 1'b0; cfg_now = 1'b0;
    check("t5_sr_clk", 96'(clk_out), 96'(3'b000));
    check("t5_sr_tick", 96'(tick), 96'(3'b000));
    check("t5_sr_div", div_active, dv(10, 4, 2));
    step(1);
    check("t5_s1", 96'(tick), 96'(3'b000));
    step(1);
    check("t5_s2", 96'(tick), 96'(3'b100));
    step(2);
    check("t5_s4", 96'(tick), 96'(3'b110));
    step(6);
    check("t5_s10", 96'(tick), 96'(3'b101));

    // Out-of-range channel write, then reset mid-count with a pending write
    wr(2'd3, 32'd7, 1'b1);
    check("t6_badch", div_active, dv(10, 4, 2));
    wr(2'd1, 32'd5, 1'b0);
    rst = 1'b1;
    step(1);
    check("t6_rst_tick", 96'(tick), 96'(3'b000));
    check("t6_rst_clk", 96'(clk_out), 96'(3'b000));
    check("t6_rst_div", div_active, dv(10000, 10000, 10000));
    rst = 1'b0;
    step(9999);
    check("t6_pre", 96'(tick), 96'(3'b000));
    step(1);
    check("t6_tick", 96'(tick), 96'(3'b111));
    check("t6_nopend", div_active, dv(10000, 10000, 10000));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
